// File: rtl/dram_arb_pkg.sv
// Shared types and defaults for the DRAM port arbiter and its helpers.
// Requester indices fix which client owns which slot of the request vectors.
package dram_arb_pkg;

  typedef enum logic [1:0] {
    A_IDLE  = 2'd0,
    A_BURST = 2'd1,
    A_DRAIN = 2'd2
  } arb_state_t;

  localparam int REQ_FETCH = 0;
  localparam int REQ_LOAD  = 1;
  localparam int REQ_STORE = 2;

  localparam int DEF_NREQ       = 3;
  localparam int DEF_ADDR_WIDTH = 24;
  localparam int DEF_LEN_WIDTH  = 10;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first requester after last_grant,
// in circular order, wins. NREQ must be at least 2.
module rr_pick #(
  parameter  int NREQ = 3,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   last_grant,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx,
  output logic            any
);

  always_comb begin
    int cand;
    // NOTE: every output gets a default before the search so no path infers a latch.
    grant     = '0;
    grant_idx = '0;
    any       = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_grant) + off) % NREQ;
      if (!any && req[IW'(cand)]) begin
        any               = 1'b1;
        grant[IW'(cand)]  = 1'b1;
        grant_idx         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one DRAM port among fetch, load and store: round-robin grant of
// whole burst descriptors, beat-by-beat streaming, tagged read return.
module dram_port_arbiter
  import dram_arb_pkg::*;
#(
  parameter int NREQ       = DEF_NREQ,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NREQ-1:0]                      req_valid,
  input  logic [NREQ-1:0]                      req_we,
  input  logic [NREQ-1:0][ADDR_WIDTH-1:0]      req_addr,
  input  logic [NREQ-1:0][LEN_WIDTH-1:0]       req_len,
  output logic [NREQ-1:0]                      req_ready,
  input  logic [NREQ-1:0][DATA_WIDTH-1:0]      wr_data,
  output logic [NREQ-1:0]                      wr_ready,
  output logic [NREQ-1:0]                      rd_valid,
  output logic [DATA_WIDTH-1:0]                rd_data,
  output logic [NREQ-1:0]                      done,
  output logic                                 busy,
  output logic [$clog2(NREQ)-1:0]              grant_id,
  output logic                                 mem_en,
  output logic                                 mem_we,
  output logic [ADDR_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                mem_wdata,
  input  logic [DATA_WIDTH-1:0]                mem_rdata
);

  localparam int IW = $clog2(NREQ);
  localparam int DW = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;

  arb_state_t           state;
  logic [IW-1:0]        owner;
  logic [IW-1:0]        last_grant;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_cnt;
  logic [DW-1:0]        drain_cnt;
  logic                 drain_last;

  logic [NREQ-1:0]      pick_onehot;
  logic [IW-1:0]        pick_idx;
  logic                 pick_any;

  logic [RD_LATENCY-1:0]         tag_v;
  logic [RD_LATENCY-1:0][IW-1:0] tag_own;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req        (req_valid),
    .last_grant (last_grant),
    .grant      (pick_onehot),
    .grant_idx  (pick_idx),
    .any        (pick_any)
  );

  assign drain_last = (state == A_DRAIN) && (drain_cnt == DW'(RD_LATENCY - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= A_IDLE;
      owner      <= '0;
      last_grant <= IW'(NREQ - 1);
      len_q      <= '0;
      beat_cnt   <= '0;
      drain_cnt  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
    end else begin
      // NOTE: non-blocking throughout so every register sees pre-edge values of the others.
      unique case (state)
        A_IDLE: begin
          if (pick_any) begin
            owner      <= pick_idx;
            last_grant <= pick_idx;
            len_q      <= req_len[pick_idx];
            beat_cnt   <= LEN_WIDTH'(1);
            drain_cnt  <= '0;
            mem_addr   <= req_addr[pick_idx];
            if (req_len[pick_idx] == '0) begin
              state <= A_DRAIN;
            end else begin
              state  <= A_BURST;
              mem_en <= 1'b1;
              mem_we <= req_we[pick_idx];
            end
          end
        end
        A_BURST: begin
          if (beat_cnt == len_q) begin
            state    <= A_DRAIN;
            mem_en   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
          end else begin
            beat_cnt <= beat_cnt + 1'b1;
            mem_addr <= mem_addr + 1'b1;  // wraps at 2^ADDR_WIDTH by width
          end
        end
        A_DRAIN: begin
          if (drain_last) state <= A_IDLE;
          else            drain_cnt <= drain_cnt + 1'b1;
        end
        default: state <= A_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the tag pipe is reset (unlike a data RAM) so reads cut off by reset never return.
      tag_v   <= '0;
      tag_own <= '0;
    end else begin
      tag_v[0]   <= mem_en & ~mem_we;
      tag_own[0] <= owner;
      for (int i = 1; i < RD_LATENCY; i++) begin
        tag_v[i]   <= tag_v[i-1];
        tag_own[i] <= tag_own[i-1];
      end
    end
  end

  // req_ready is combinational on req_valid, so it is also held low while in reset.
  always_comb begin
    req_ready = '0;
    wr_ready  = '0;
    rd_valid  = '0;
    done      = '0;
    if (state == A_IDLE && !rst) req_ready = pick_onehot;
    if (mem_en && mem_we)        wr_ready[owner] = 1'b1;
    if (tag_v[RD_LATENCY-1])     rd_valid[tag_own[RD_LATENCY-1]] = 1'b1;
    if (drain_last)              done[owner] = 1'b1;
  end

  assign rd_data   = tag_v[RD_LATENCY-1] ? mem_rdata : '0;
  assign mem_wdata = (mem_en && mem_we) ? wr_data[owner] : '0;
  assign busy      = (state != A_IDLE);
  assign grant_id  = owner;

  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_rd_onehot:    assert property (@(posedge clk) disable iff (rst) $onehot0(rd_valid));
  a_done_onehot:  assert property (@(posedge clk) disable iff (rst) $onehot0(done));

endmodule
